// File: rtl/adder_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit adder.
// The adder sees only registered operands and is sampled SETTLE_CYCLES edges after acceptance.
module adder_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        owner_q, owner_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        id_q, id_d;

  logic        grant_vld;
  logic        grant_id;
  logic        cnt_zero;
  logic [31:0] add_sum;
  logic        add_cout;

  // The single shared adder; carry-in is tied low.
  assign {add_cout, add_sum} = 33'(op_a_q) + 33'(op_b_q) + 33'(1'b0);

  assign cnt_zero = (cnt_q == 4'd0);

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state_q == StIdle && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld & grant_id;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant_vld) state_d = StBusy;
      StBusy: if (cnt_zero) state_d = StDone;
      StDone: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rsp_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    owner_d      = owner_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    id_d         = id_q;
    if (state_q == StIdle && grant_vld) begin
      cnt_d        = CntLoad;
      last_grant_d = grant_id;
      owner_d      = grant_id;
      op_a_d       = grant_id ? req1_a : req0_a;
      op_b_d       = grant_id ? req1_b : req0_b;
    end else if (state_q == StBusy) begin
      if (cnt_zero) begin
        sum_d  = add_sum;
        cout_d = add_cout;
        id_d   = owner_q;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      owner_q      <= 1'b0;
      sum_q        <= 32'd0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      owner_q      <= owner_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: instances with SETTLE_CYCLES 2 (main), 1 and 15 share stimulus.
module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [31:0] rsp_sum;
  logic        s1_r0, s1_r1, s1_valid, s1_id, s1_cout, s1_busy;
  logic [31:0] s1_sum;
  logic        s15_r0, s15_r1, s15_valid, s15_id, s15_cout, s15_busy;
  logic [31:0] s15_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .busy(busy)
  );

  adder_arbiter #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s1_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s1_r1),
    .rsp_valid(s1_valid), .rsp_ready(rsp_ready), .rsp_id(s1_id), .rsp_sum(s1_sum),
    .rsp_cout(s1_cout), .busy(s1_busy)
  );

  adder_arbiter #(.SETTLE_CYCLES(15)) u_dut_s15 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(s15_r0),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(s15_r1),
    .rsp_valid(s15_valid), .rsp_ready(rsp_ready), .rsp_id(s15_id), .rsp_sum(s15_sum),
    .rsp_cout(s15_cout), .busy(s15_busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at posedge+1 of the handshake edge; ok=0 if never granted.
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  // Edges after the call until rsp_valid is seen; -1 on timeout.
  task automatic wait_rsp(output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #12;
    checks++;
    if ({rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got v=%b c=%b id=%b busy=%b r0=%b r1=%b want all 0",
               rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready);
    end
    checks++;
    if (rsp_sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_sum: got %h want 00000000", rsp_sum);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int edges;
    send(1'b0, 32'h0000_0005, 32'h0000_0003, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_grant: got no grant want grant"); end
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_busy: got busy=%b v=%b want busy=1 v=0", busy, rsp_valid);
    end
    wait_rsp(edges);
    checks++;
    if (edges != 2) begin failures++; $display("FAIL single_latency: got %0d want 2", edges); end
    checks++;
    if (rsp_sum !== 32'h8 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got sum=%h c=%b id=%b want 00000008/0/0",
               rsp_sum, rsp_cout, rsp_id);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int edges;
    send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, ok);
    wait_rsp(edges);
    checks++;
    if (!ok || edges != 2) begin
      failures++;
      $display("FAIL ovf_latency: got ok=%0d edges=%0d want 1/2", ok, edges);
    end
    checks++;
    if (rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 1'b1) begin
      failures++;
      $display("FAIL ovf_rsp: got sum=%h c=%b id=%b want 00000000/1/1",
               rsp_sum, rsp_cout, rsp_id);
    end
    consume();
  endtask

  task automatic test_fairness();
    bit found;
    do_reset();
    @(negedge clk);
    req0_a = 32'd1; req0_b = 32'd1; req1_a = 32'd2; req1_b = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        checks++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
          failures++;
          $display("FAIL fair_onehot: got r0=1 r1=1 want at most one");
        end
        if (rsp_valid === 1'b1) begin found = 1'b1; break; end
      end
      checks++;
      if (!found || rsp_id !== k[0] || rsp_sum !== (k[0] ? 32'd4 : 32'd2)) begin
        failures++;
        $display("FAIL fair_rsp%0d: got found=%0d id=%b sum=%h want id=%0d sum=%0d",
                 k, found, rsp_id, rsp_sum, k % 2, k[0] ? 4 : 2);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    send(1'b0, 32'h1234_5678, 32'h1111_1111, ok);
    wait_rsp(edges);
    checks++;
    if (!ok || edges != 2) begin
      failures++;
      $display("FAIL bp_latency: got ok=%0d edges=%0d want 1/2", ok, edges);
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h2345_6789 || rsp_id !== 1'b0 ||
          rsp_cout !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d: got v=%b sum=%h id=%b c=%b r0=%b r1=%b busy=%b want 1/23456789/0/0/0/0/1",
                 i, rsp_valid, rsp_sum, rsp_id, rsp_cout, req0_ready, req1_ready, busy);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_take: got v=%b busy=%b want 0/0 (no accept on rsp edge)", rsp_valid, busy);
    end
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int edges;
    send(1'b0, 32'd7, 32'd7, ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready} !== 6'b0 ||
        rsp_sum !== 32'd0) begin
      failures++;
      $display("FAIL abort_outputs: got v=%b c=%b id=%b busy=%b sum=%h want reset values",
               rsp_valid, rsp_cout, rsp_id, busy, rsp_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet%0d: got v=%b busy=%b want 0/0", i, rsp_valid, busy);
      end
    end
    @(negedge clk);
    req0_a = 32'd9; req0_b = 32'd1; req1_a = 32'd20; req1_b = 32'd22;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_tie: got r0=%b r1=%b want 1/0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(edges);
    checks++;
    if (edges != 2 || rsp_id !== 1'b0 || rsp_sum !== 32'd10) begin
      failures++;
      $display("FAIL abort_rsp: got edges=%0d id=%b sum=%h want 2/0/0000000a",
               edges, rsp_id, rsp_sum);
    end
    consume();
  endtask

  task automatic test_settle();
    bit ok;
    int e1, e2, e15;
    do_reset();
    send(1'b0, 32'd100, 32'd23, ok);
    e1 = -1; e2 = -1; e15 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (s1_valid === 1'b1 && e1 < 0) e1 = i;
      if (rsp_valid === 1'b1 && e2 < 0) e2 = i;
      if (s15_valid === 1'b1 && e15 < 0) e15 = i;
    end
    checks++;
    if (!ok || e1 != 1) begin
      failures++;
      $display("FAIL settle1_latency: got ok=%0d edges=%0d want 1/1", ok, e1);
    end
    checks++;
    if (e2 != 2) begin failures++; $display("FAIL settle2_latency: got %0d want 2", e2); end
    checks++;
    if (e15 != 15) begin failures++; $display("FAIL settle15_latency: got %0d want 15", e15); end
    checks++;
    if (s1_sum !== 32'd123 || s15_sum !== 32'd123 || s1_id !== 1'b0 || s15_id !== 1'b0) begin
      failures++;
      $display("FAIL settle_sum: got s1=%h s15=%h ids=%b%b want 0000007b/0000007b/00",
               s1_sum, s15_sum, s1_id, s15_id);
    end
    consume();
    checks++;
    if (s1_valid !== 1'b0 || s15_valid !== 1'b0 || s1_busy !== 1'b0 || s15_busy !== 1'b0) begin
      failures++;
      $display("FAIL settle_take: got v1=%b v15=%b b1=%b b15=%b want 0", s1_valid, s15_valid,
               s1_busy, s15_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_reset_abort();
    test_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
